// File: rtl/mux4_sel_pkg.sv
// Shared select encoding for the mux4 selector family: select type, named
// select codes and the helper that packs the two select pins into a code.
package mux4_sel_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

  // sel1 is the MSB and sel2 is the LSB of the select code.
  function automatic sel_t make_sel(input logic sel1, input logic sel2);
    return {sel1, sel2};
  endfunction

endpackage

// File: rtl/mux4_comb.sv
// Purely combinational WIDTH-bit 4:1 selector. It has no state and no
// clock, and its output follows the inputs with zero latency.
module mux4_comb
  import mux4_sel_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  // In simulation, an unknown select drives the output to all-X.
  // Synthesis treats that default branch as a don't-care.
  always_comb begin
    y = 'x;
    case (sel)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      SEL_D:   y = d;
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/mux4_sel_reg.sv
// 4:1 data selector with a combinational output Y and a registered copy y_q.
// Define MUX4_SEL_PARITY_EN to add par_q, the registered even parity of Y.
module mux4_sel_reg
  import mux4_sel_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic             sel1,
  input  logic             sel2,
  input  logic             en,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] y_q
`ifdef MUX4_SEL_PARITY_EN
  ,
  output logic             par_q
`endif
);

  sel_t sel;

  assign sel = make_sel(sel1, sel2);

  mux4_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .a   (A),
    .b   (B),
    .c   (C),
    .d   (D),
    .sel (sel),
    .y   (Y)
  );

  // Reset takes priority over en. When en is low, the register holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q <= RESET_VAL;
    end else if (en) begin
      y_q <= Y;
    end
  end

`ifdef MUX4_SEL_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (en) begin
      par_q <= ^Y;
    end
  end
`endif

endmodule

// File: tb/tb_mux4_sel_reg.sv
// Directed bench for mux4_sel_reg, using a 1-bit instance and an 8-bit
// instance with a non-zero RESET_VAL. Parity checks run when MUX4_SEL_PARITY_EN is defined.
module tb_mux4_sel_reg;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst_n;

  // 1-bit instance
  logic a1, b1, c1, d1, s1_1, s2_1, en1;
  logic y1, yq1;

  // 8-bit instance
  logic [7:0] a8, b8, c8, d8;
  logic       s1_8, s2_8, en8;
  logic [7:0] y8, yq8;
`ifdef MUX4_SEL_PARITY_EN
  logic       par1, par8;
`endif

  localparam logic [7:0] RV8 = 8'h5A;

  always #5 clk = ~clk;

  mux4_sel_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a1),
    .B     (b1),
    .C     (c1),
    .D     (d1),
    .sel1  (s1_1),
    .sel2  (s2_1),
    .en    (en1),
    .Y     (y1),
    .y_q   (yq1)
`ifdef MUX4_SEL_PARITY_EN
    ,
    .par_q (par1)
`endif
  );

  mux4_sel_reg #(.WIDTH(8), .RESET_VAL(RV8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a8),
    .B     (b8),
    .C     (c8),
    .D     (d8),
    .sel1  (s1_8),
    .sel2  (s2_8),
    .en    (en8),
    .Y     (y8),
    .y_q   (yq8)
`ifdef MUX4_SEL_PARITY_EN
    ,
    .par_q (par8)
`endif
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input logic [1:0] s, input logic a, input logic b,
                      input logic c, input logic d);
    {s1_1, s2_1} = s;
    a1 = a; b1 = b; c1 = c; d1 = d;
    #1;
  endtask

  task automatic set8(input logic [1:0] s);
    {s1_8, s2_8} = s;
    #1;
  endtask

  initial begin
    // Reset with en high and Y=1 on the 1-bit instance.
    rst_n = 1'b0;
    en1 = 1'b1;
    en8 = 1'b1;
    set1(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
    set8(2'b11);
    tick();
    check("rst_yq1", {7'b0, yq1}, 8'h00);
    check("rst_yq8", yq8, RV8);
    check("rst_y_comb8", y8, 8'h44);
`ifdef MUX4_SEL_PARITY_EN
    check("rst_par8", {7'b0, par8}, 8'h00);
`endif

    // One-hot walk. Reset is still asserted and does not affect Y.
    set1(2'b00, 1'b1, 1'b0, 1'b0, 1'b0); check("walk_00", {7'b0, y1}, 8'h01);
    set1(2'b01, 1'b0, 1'b1, 1'b0, 1'b0); check("walk_01", {7'b0, y1}, 8'h01);
    set1(2'b10, 1'b0, 1'b0, 1'b1, 1'b0); check("walk_10", {7'b0, y1}, 8'h01);
    set1(2'b11, 1'b0, 1'b0, 1'b0, 1'b1); check("walk_11", {7'b0, y1}, 8'h01);

    // Non-selected isolation: only the selected input is 0.
    set1(2'b00, 1'b0, 1'b1, 1'b1, 1'b1); check("iso_00", {7'b0, y1}, 8'h00);
    set1(2'b01, 1'b1, 1'b0, 1'b1, 1'b1); check("iso_01", {7'b0, y1}, 8'h00);
    set1(2'b10, 1'b1, 1'b1, 1'b0, 1'b1); check("iso_10", {7'b0, y1}, 8'h00);
    set1(2'b11, 1'b1, 1'b1, 1'b1, 1'b0); check("iso_11", {7'b0, y1}, 8'h00);
    tick();
    check("rst_hold_yq1", {7'b0, yq1}, 8'h00);

    // Release reset with en=1, sel=11 and D=1.
    en8 = 1'b0;
    rst_n = 1'b1;
    set1(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("release_yq1", {7'b0, yq1}, 8'h01);
    check("en0_hold_yq8", yq8, RV8);

    // Enable hold for three edges, then load.
    en1 = 1'b0;
    set1(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("hold_y1", {7'b0, y1}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_yq1", {7'b0, yq1}, 8'h01);
    end
    en1 = 1'b1;
    tick();
    check("load_yq1", {7'b0, yq1}, 8'h00);

    // Reset mid-operation, then resume loading.
    set1(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("mid_load_yq1", {7'b0, yq1}, 8'h01);
    rst_n = 1'b0;
    tick();
    check("mid_rst_yq1", {7'b0, yq1}, 8'h00);
    rst_n = 1'b1;
    en1 = 1'b0;
    tick();
    check("mid_en0_yq1", {7'b0, yq1}, 8'h00);
    en1 = 1'b1;
    tick();
    check("mid_resume_yq1", {7'b0, yq1}, 8'h01);

    // Wide sweep: y_q trails Y by one edge.
    en8 = 1'b1;
    set8(2'b00); check("wide_y_00", y8, 8'h11);
    tick();      check("wide_yq_00", yq8, 8'h11);
    set8(2'b01); check("wide_y_01", y8, 8'h22);
                 check("wide_trail_01", yq8, 8'h11);
    tick();      check("wide_yq_01", yq8, 8'h22);
    set8(2'b10); check("wide_y_10", y8, 8'h33);
                 check("wide_trail_10", yq8, 8'h22);
    tick();      check("wide_yq_10", yq8, 8'h33);
    set8(2'b11); check("wide_y_11", y8, 8'h44);
                 check("wide_trail_11", yq8, 8'h33);
    tick();      check("wide_yq_11", yq8, 8'h44);

    // Change data and select together. Y follows immediately.
    c8 = 8'h07;
    set8(2'b10); check("simul_y", y8, 8'h07);
    tick();      check("simul_yq", yq8, 8'h07);
`ifdef MUX4_SEL_PARITY_EN
    check("par_c07", {7'b0, par8}, 8'h01);
`endif
    d8 = 8'h03;
    set8(2'b11);
    tick();      check("d03_yq", yq8, 8'h03);
`ifdef MUX4_SEL_PARITY_EN
    check("par_d03", {7'b0, par8}, 8'h00);
`endif
    set8(2'b10);
    tick();
`ifdef MUX4_SEL_PARITY_EN
    check("par_c07_again", {7'b0, par8}, 8'h01);
`endif
    rst_n = 1'b0;
    tick();
    check("wide_rst_yq8", yq8, RV8);
`ifdef MUX4_SEL_PARITY_EN
    check("par_rst", {7'b0, par8}, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
